axi_ram_slave: RTL
==================

Name: axi_ram_slave

Overview:
- AXI3 slave (responder) backed by a word-organised synchronous RAM: the other end of the CPU's AXI master port.
- Used in the simulation/SoC shell to serve instruction and data traffic from the CPU's AXI interface, including cache-line bursts and uncached single beats.
- Read and write channels are independent; each side has one burst outstanding at a time.

Parameters:
MEM_AW, 14, log2 of RAM depth in 32-bit words; byte address bits [MEM_AW+1:2] index the RAM, higher bits ignored (aliasing)
ID_W, 4, width of arid/rid/awid/wid/bid
INIT_FILE, "", optional $readmemh image loaded at elaboration

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
arid  in  ID_W  read ID
araddr  in  32  read byte address
arlen  in  8  beats-1
arsize  in  3  bytes per beat (log2); only 3'b010 served full-word, others treated as word
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
arlock/arcache/arprot  in  2/4/3  ignored
arvalid  in  1  read address valid
arready  out  1  read address accept
rid  out  ID_W  read ID echo
rdata  out  32  read data
rresp  out  2  response
rlast  out  1  final read beat
rvalid  out  1  read data valid
rready  in  1  master accepts read beat
awid/awaddr/awlen/awsize/awburst  in  ID_W/32/8/3/2  write address, same encoding as AR
awlock/awcache/awprot  in  2/4/3  ignored
awvalid  in  1; awready  out  1
wid  in  ID_W  ignored (no interleaving)
wdata  in  32; wstrb  in  4  byte enables; wlast  in  1
wvalid  in  1; wready  out  1
bid  out  ID_W; bresp  out  2; bvalid  out  1; bready  in  1

Behaviour:
- Reset (rst=1, asynchronous): read FSM -> R_IDLE, write FSM -> W_IDLE; rvalid, rlast, bvalid, wready, arready, awready = 0; rid, rdata, rresp, bid, bresp = 0; beat counters = 0. RAM contents are NOT cleared.
- In-flight bursts are abandoned on reset; no response is issued afterwards.
- arready = (state==R_IDLE) && !rst; awready = (state==W_IDLE) && !rst.
- Read FSM:
  - R_IDLE: on arvalid&&arready, latch id, addr, len, burst; cnt=0 -> R_DATA.
  - R_DATA: RAM is read synchronously. rvalid=1 exactly one cycle after the AR handshake, with rdata=mem[idx(addr)], rid=latched id, rresp=00, rlast=(cnt==len).
  - On rvalid&&rready: if rlast -> R_IDLE (rvalid drops next cycle); else advance address, cnt++, and present the next beat on the following cycle (no bubble while rready is held).
  - rvalid/rdata/rlast are held stable while rready=0.
- Address advance: FIXED keeps addr; INCR adds 4; WRAP adds 4 within an aligned (len+1)*4 byte window, where len must be 1/3/7/15.
- WRAP with an illegal len is treated as INCR and the burst responds 2'b10 (SLVERR) on every beat.
- Write FSM:
  - W_IDLE: on awvalid&&awready, latch id, addr, len, burst; cnt=0 -> W_DATA.
  - W_DATA: wready=1. Each wvalid&&wready writes the bytes of wdata selected by wstrb to mem[idx(addr)], then advances address and cnt.
  - The beat with cnt==len ends the burst -> W_RESP.
  - A wlast value that does not match (cnt==len) on any beat sets a sticky err.
  - W_RESP: bvalid=1, bid=latched id, bresp = err ? 10 : 00. On bready -> W_IDLE, err cleared.
- Back-to-back: a new AR/AW is accepted no earlier than the cycle after returning to IDLE, so there is one idle cycle between bursts.
- Same-cycle read and write to the same word: the read returns the old data (read-first).
- W data arriving before AW is stalled (wready=0 in W_IDLE); no W buffering.
- Address arithmetic is 32-bit and wraps modulo 2^32; RAM index = addr[MEM_AW+1:2].

Test Plan:
- Single read: preload mem[0x40>>2]=0xDEADBEEF; AR addr=0x40, len=0, id=3, rready=1 -> one cycle later rvalid=1, rdata=0xDEADBEEF, rid=3, rlast=1, rresp=00; arready returns high 2 cycles after the handshake.
- INCR write burst then read: AW addr=0x100, len=3, id=5; W 0x11,0x22,0x33,0x44 with wlast on beat 4 -> bvalid, bid=5, bresp=00. Then an AR len=3 returns the same four words in order, rlast only on beat 4, with no bubbles.
- Byte strobes: mem[0x200>>2]=0xAABBCCDD; write 0x11223344, wstrb=0101 -> readback 0xAA22CC44.
- WRAP read: AR addr=0x1C, len=3, burst=10 -> beats from 0x1C, 0x10, 0x14, 0x18.
- Backpressure and error: rready toggles 1,0,0,1 during a read -> rdata stable while stalled, no beat lost. A write with len=1 and wlast on beat 1 -> bresp=10 after beat 2.
- Reset mid-burst: assert rst during beat 2 of a len=7 read -> rvalid=0 asynchronously. After release, arready=1 and a new read returns correct data with no stale beats.

Source files
------------

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI3 responder backed by a word-organised synchronous RAM.
// The read and write channels run independently. Each channel handles one
// burst at a time.
//
// Ports:
//   clk, rst           rising-edge clock; asynchronous active-high reset
//   ar* / r*           read address channel in, read data channel out
//   aw* / w* / b*      write address and write data channels in, write response out
//   *lock/*cache/*prot, *size, wid are accepted and ignored
//
// Handshake: a transfer on any channel happens on the rising edge where its
// valid and ready are both 1. A valid, once raised, holds its payload stable
// until that edge.
// RAM index is addr[MEM_AW+1:2]. Higher address bits alias.
module axi_ram_slave #(
  parameter int    MEM_AW    = 14,
  parameter int    ID_W      = 4,
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [31:0] mem [DEPTH];

  // The WRAP window is (len+1) words. Only power-of-two lengths of 2 to 16 beats form a legal window.
  function automatic logic wrap_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // FIXED keeps the address. A legal WRAP steps by one word inside the aligned window.
  // INCR, reserved 2'b11 and an illegal WRAP all add 4, modulo 2^32.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [1:0] burst);
    logic [31:0] mask;
    mask = {22'd0, len, 2'b11};
    if (burst == 2'b00)                          return addr;
    else if (burst == 2'b10 && wrap_legal(len))  return (addr & ~mask) | ((addr + 32'd4) & mask);
    else                                         return addr + 32'd4;
  endfunction

  // ---------------- read channel ----------------
  r_state_e        r_state_q, r_state_d;
  logic [ID_W-1:0] r_id_q, r_id_d;
  logic [31:0]     r_addr_q, r_addr_d;
  logic [7:0]      r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [1:0]      r_burst_q, r_burst_d;
  logic            r_err_q, r_err_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0]     rdata_q;
  logic            rd_en;
  logic [MEM_AW-1:0] rd_idx;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    r_err_d   = r_err_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rd_en     = 1'b0;
    rd_idx    = r_addr_q[MEM_AW+1:2];
    case (r_state_q)
      R_IDLE: if (arvalid && arready) begin
        r_state_d = R_DATA;
        r_id_d    = arid;
        r_addr_d  = araddr;
        r_len_d   = arlen;
        r_burst_d = arburst;
        r_cnt_d   = 8'd0;
        r_err_d   = (arburst == 2'b10) && !wrap_legal(arlen);
        rd_en     = 1'b1;
        rd_idx    = araddr[MEM_AW+1:2];
        rvalid_d  = 1'b1;
        rlast_d   = (arlen == 8'd0);
      end
      R_DATA: if (rready) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
        end else begin
          // Fetch the next beat in this cycle so it appears without a bubble.
          r_addr_d = next_addr(r_addr_q, r_len_q, r_burst_q);
          r_cnt_d  = r_cnt_q + 8'd1;
          rd_en    = 1'b1;
          rd_idx   = r_addr_d[MEM_AW+1:2];
          rlast_d  = (r_cnt_d == r_len_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_err_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      r_err_q   <= r_err_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      // A read in the same cycle as a write to the same word returns the old word.
      if (rd_en) rdata_q <= mem[rd_idx];
    end
  end

  assign arready = (r_state_q == R_IDLE) && !rst;
  assign rid     = r_id_q;
  assign rdata   = rdata_q;
  assign rresp   = r_err_q ? 2'b10 : 2'b00;
  assign rlast   = rlast_q;
  assign rvalid  = rvalid_q;

  // ---------------- write channel ----------------
  w_state_e        w_state_q, w_state_d;
  logic [ID_W-1:0] w_id_q, w_id_d;
  logic [31:0]     w_addr_q, w_addr_d;
  logic [7:0]      w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [1:0]      w_burst_q, w_burst_d, bresp_q, bresp_d;
  logic            w_err_q, w_err_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic            mem_we, beat_last;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    beat_last = (w_cnt_q == w_len_q);
    case (w_state_q)
      W_IDLE: if (awvalid && awready) begin
        w_state_d = W_DATA;
        w_id_d    = awid;
        w_addr_d  = awaddr;
        w_len_d   = awlen;
        w_burst_d = awburst;
        w_cnt_d   = 8'd0;
        w_err_d   = (awburst == 2'b10) && !wrap_legal(awlen);
        wready_d  = 1'b1;
      end
      W_DATA: if (wvalid) begin
        mem_we   = 1'b1;
        w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
        w_cnt_d  = w_cnt_q + 8'd1;
        // The beat count ends the burst. A wlast on the wrong beat only flags an error.
        if (wlast != beat_last) w_err_d = 1'b1;
        if (beat_last) begin
          w_state_d = W_RESP;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = w_err_d ? 2'b10 : 2'b00;
        end
      end
      W_RESP: if (bready) begin
        w_state_d = W_IDLE;
        bvalid_d  = 1'b0;
        w_err_d   = 1'b0;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // The RAM array has no reset. Its contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_addr_q[MEM_AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign awready = (w_state_q == W_IDLE) && !rst;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = w_id_q;
  assign bresp   = bresp_q;

  logic unused_sigs;
  assign unused_sigs = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot, wid};
endmodule
